// File: rtl/phy_modport_if.sv
// MAC-side bundle of the MII nibble adapter: RX show-ahead pop port,
// TX push port and the FIFO status flags.
interface phy_modport_if;
  logic       rx_pop;
  logic       rx_out_valid;
  logic [3:0] rx_out_nibble;
  logic       rx_empty;
  logic       rx_full;
  logic       tx_push;
  logic       tx_in_valid;
  logic [3:0] tx_in_nibble;
  logic       tx_full;
  logic       tx_empty;

  modport master (
    output rx_pop,
    input  rx_out_valid,
    input  rx_out_nibble,
    input  rx_empty,
    input  rx_full,
    output tx_push,
    output tx_in_valid,
    output tx_in_nibble,
    input  tx_full,
    input  tx_empty
  );

  modport slave (
    input  rx_pop,
    output rx_out_valid,
    output rx_out_nibble,
    output rx_empty,
    output rx_full,
    input  tx_push,
    input  tx_in_valid,
    input  tx_in_nibble,
    output tx_full,
    output tx_empty
  );
endinterface

// File: rtl/phy_modport.sv
// MII nibble adapter: RX FIFO (show-ahead) and TX FIFO drained onto MII.
// Optional PHY_MODPORT_OVERFLOW_EN adds sticky rx/tx overflow flags.
module phy_modport #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       eth_mac_clock,
  input  logic       eth_mac_rst,
  input  logic [3:0] eth_mii_rxd,
  input  logic       eth_mii_rx_dv,
  output logic [3:0] eth_mii_txd,
  output logic       eth_mii_tx_en,
  phy_modport_if.slave mac
`ifdef PHY_MODPORT_OVERFLOW_EN
  ,
  output logic       rx_overflow,
  output logic       tx_overflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [4:0]    rx_mem [FIFO_DEPTH];
  logic [4:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_rd, rx_wr;
  logic [AW-1:0] tx_rd, tx_wr;

  logic rx_empty_w, rx_full_w;
  logic tx_empty_w, tx_full_w;
  logic rx_push_ok, rx_pop_ok;
  logic tx_push_ok;

  assign rx_empty_w = (rx_rd == rx_wr);
  assign rx_full_w  = ((rx_wr + AW'(1)) == rx_rd);
  assign tx_empty_w = (tx_rd == tx_wr);
  assign tx_full_w  = ((tx_wr + AW'(1)) == tx_rd);

  assign rx_push_ok = eth_mii_rx_dv & ~rx_full_w;
  assign rx_pop_ok  = mac.rx_pop & ~rx_empty_w;
  assign tx_push_ok = mac.tx_push & ~tx_full_w;

  assign mac.rx_empty      = rx_empty_w;
  assign mac.rx_full       = rx_full_w;
  assign mac.tx_empty      = tx_empty_w;
  assign mac.tx_full       = tx_full_w;
  assign mac.rx_out_valid  = ~rx_empty_w & rx_mem[rx_rd][4];
  assign mac.rx_out_nibble = rx_empty_w ? 4'h0 : rx_mem[rx_rd][3:0];

  // Storage needs no reset; pointers alone define what is live.
  always_ff @(posedge eth_mac_clock) begin
    if (rx_push_ok) rx_mem[rx_wr] <= {1'b1, eth_mii_rxd};
    if (tx_push_ok) tx_mem[tx_wr] <= {mac.tx_in_valid, mac.tx_in_nibble};
  end

  always_ff @(posedge eth_mac_clock) begin
    if (eth_mac_rst) begin
      rx_rd         <= '0;
      rx_wr         <= '0;
      tx_rd         <= '0;
      tx_wr         <= '0;
      eth_mii_txd   <= 4'h0;
      eth_mii_tx_en <= 1'b0;
    end else begin
      if (rx_push_ok) rx_wr <= rx_wr + AW'(1);
      if (rx_pop_ok)  rx_rd <= rx_rd + AW'(1);
      if (tx_push_ok) tx_wr <= tx_wr + AW'(1);
      if (!tx_empty_w) begin
        eth_mii_txd   <= tx_mem[tx_rd][3:0];
        eth_mii_tx_en <= tx_mem[tx_rd][4];
        tx_rd         <= tx_rd + AW'(1);
      end else begin
        eth_mii_txd   <= 4'h0;
        eth_mii_tx_en <= 1'b0;
      end
    end
  end

`ifdef PHY_MODPORT_OVERFLOW_EN
  always_ff @(posedge eth_mac_clock) begin
    if (eth_mac_rst) begin
      rx_overflow <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (eth_mii_rx_dv & rx_full_w) rx_overflow <= 1'b1;
      if (mac.tx_push & tx_full_w)   tx_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_phy_modport.sv
// Bench for phy_modport: queue-based FIFO reference model, directed
// scenarios followed by randomized traffic with occasional resets.
module tb_phy_modport;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rxd = 4'h0;
  logic       rx_dv = 1'b0;
  logic [3:0] txd;
  logic       tx_en;
`ifdef PHY_MODPORT_OVERFLOW_EN
  logic       rx_ovf, tx_ovf;
`endif

  phy_modport_if mif();

  phy_modport #(.FIFO_DEPTH(D)) dut (
    .eth_mac_clock (clk),
    .eth_mac_rst   (rst),
    .eth_mii_rxd   (rxd),
    .eth_mii_rx_dv (rx_dv),
    .eth_mii_txd   (txd),
    .eth_mii_tx_en (tx_en),
    .mac           (mif.slave)
`ifdef PHY_MODPORT_OVERFLOW_EN
    ,
    .rx_overflow   (rx_ovf),
    .tx_overflow   (tx_ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFOs as bounded queues, MII as last drained entry.
  logic [3:0] rxq[$];
  logic [4:0] txq[$];
  logic [4:0] exp_mii = 5'h0;
  bit         exp_rx_ovf = 0;
  bit         exp_tx_ovf = 0;
  bit         armed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      rxq.delete();
      txq.delete();
      exp_mii    = 5'h0;
      exp_rx_ovf = 0;
      exp_tx_ovf = 0;
      armed      = 1;
    end else if (armed) begin
      int rn, tn;
      rn = rxq.size();
      tn = txq.size();
      if (mif.rx_pop && rn > 0) void'(rxq.pop_front());
      if (rx_dv) begin
        if (rn < D - 1) rxq.push_back(rxd);
        else exp_rx_ovf = 1;
      end
      if (tn > 0) exp_mii = txq.pop_front();
      else exp_mii = 5'h0;
      if (mif.tx_push) begin
        if (tn < D - 1) txq.push_back({mif.tx_in_valid, mif.tx_in_nibble});
        else exp_tx_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      int n;
      n = rxq.size();
      check("rx_empty", int'(mif.rx_empty), int'(n == 0));
      check("rx_full", int'(mif.rx_full), int'(n == D - 1));
      check("rx_out_valid", int'(mif.rx_out_valid), int'(n > 0));
      check("rx_out_nibble", int'(mif.rx_out_nibble),
            n > 0 ? int'(rxq[0]) : 0);
      check("tx_empty", int'(mif.tx_empty), int'(txq.size() == 0));
      check("tx_full", int'(mif.tx_full), int'(txq.size() == D - 1));
      check("mii_txd", int'(txd), int'(exp_mii[3:0]));
      check("mii_tx_en", int'(tx_en), int'(exp_mii[4]));
`ifdef PHY_MODPORT_OVERFLOW_EN
      check("rx_overflow", int'(rx_ovf), int'(exp_rx_ovf));
      check("tx_overflow", int'(tx_ovf), int'(exp_tx_ovf));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_dv = 0;
    mif.rx_pop = 0;
    mif.tx_push = 0;
    mif.tx_in_valid = 0;
    mif.tx_in_nibble = 4'h0;
  endtask

  task automatic tx_put(input logic v, input logic [3:0] n);
    mif.tx_push = 1;
    mif.tx_in_valid = v;
    mif.tx_in_nibble = n;
  endtask

  initial begin
    idle();
    // Reset with traffic present on the inputs
    rst = 1;
    rx_dv = 1;
    rxd = 4'h9;
    tx_put(1, 4'h7);
    step();
    step();
    rst = 0;
    idle();
    step();
    check("reset_txen", int'(tx_en), 0);
    check("reset_rx_empty", int'(mif.rx_empty), 1);

    // RX stream 1,2,3 then pop until empty
    for (int i = 1; i <= 3; i++) begin
      rx_dv = 1;
      rxd = 4'(i);
      step();
    end
    rx_dv = 0;
    check("rx_stream_head", int'(mif.rx_out_nibble), 1);
    for (int i = 0; i < 3; i++) begin
      mif.rx_pop = 1;
      step();
    end
    mif.rx_pop = 0;
    check("rx_stream_drained", int'(mif.rx_out_valid), 0);

    // RX overflow: 9 nibbles, no pop
    for (int i = 0; i < 9; i++) begin
      rx_dv = 1;
      rxd = 4'(i);
      step();
    end
    rx_dv = 0;
    check("rx_overflow_full", int'(mif.rx_full), 1);
    for (int i = 0; i < 7; i++) begin
      mif.rx_pop = 1;
      step();
    end
    mif.rx_pop = 0;

    // TX drain: A/1, 5/1, 0/0
    tx_put(1, 4'hA);
    step();
    tx_put(1, 4'h5);
    step();
    tx_put(0, 4'h0);
    step();
    idle();
    check("tx_drain_second", int'(txd), 5);
    step();
    step();
    step();

    // Simultaneous push/pop across pointer wrap
    rx_dv = 1;
    rxd = 4'hF;
    step();
    for (int i = 0; i < 20; i++) begin
      rx_dv = 1;
      rxd = 4'(i);
      mif.rx_pop = 1;
      step();
    end
    idle();
    mif.rx_pop = 1;
    step();
    mif.rx_pop = 0;

    // Random traffic with rare resets
    for (int i = 0; i < 1500; i++) begin
      int mode;
      mode = (i / 150) % 3;
      rst = ($urandom_range(0, 99) == 0);
      rx_dv = ($urandom_range(0, 3) != 0);
      rxd = 4'($urandom);
      mif.rx_pop = (mode == 0) ? ($urandom_range(0, 7) == 0)
                               : ($urandom_range(0, 1) == 1);
      mif.tx_push = ($urandom_range(0, 2) != 0);
      mif.tx_in_valid = 1'($urandom);
      mif.tx_in_nibble = 4'($urandom);
      step();
    end
    rst = 0;
    idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
